sp_ram_arbiter: RTL and testbench
=================================

SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

Interface
REQ-001 Parameters SHALL be: RAM_WIDTH, default 16, data width; ADDR_SIZE, default 3, address width.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_a, req_b  in  1  access request, held high with stable command until granted.
REQ-006 we_a, we_b  in  1  1 = write, 0 = read; sampled with req.
REQ-007 addr_a, addr_b  in  ADDR_SIZE  word address.
REQ-008 wdata_a, wdata_b  in  RAM_WIDTH  write data.
REQ-009 gnt_a, gnt_b  out  1  one-cycle pulse: command captured; requester may change inputs next cycle.
REQ-010 ack_a, ack_b  out  1  one-cycle pulse: access complete.
REQ-011 rdata_a, rdata_b  out  RAM_WIDTH  read data, valid in the ack cycle of a read, held until the next read ack for that port.
REQ-012 clr_req  in  1  request to zero the whole RAM.
REQ-013 clr_ack  out  1  one-cycle pulse: clear complete.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 ram_en, ram_wr, ram_oe, ram_rst  out  1  RAM strobe, write select, output enable, RAM clear.
REQ-016 ram_addr  out  ADDR_SIZE  RAM address.
REQ-017 ram_data  inout  RAM_WIDTH  RAM data bus; driven only while ram_wr = 1, else high-Z.

Function
REQ-018 The FSM SHALL have states IDLE, SETUP, STROBE, FINISH, CLEAR; all RAM-side outputs and pulses SHALL be registered.
REQ-019 IDLE: clr_req high -> CLEAR (clear beats all requests); else any req -> SETUP with the arbitration winner captured; else stay.
REQ-020 Arbitration SHALL be round-robin: single request wins; both requesting -> port not granted last wins; after reset A has priority.
REQ-021 SETUP: gnt of winner = 1; ram_addr/ram_wr set from captured command; ram_en = 0, ram_oe = 0; write data driven on ram_data if write.
REQ-022 STROBE: ram_en = 1 (RAM acts on this rising edge); ram_addr, ram_wr, write data unchanged.
REQ-023 FINISH, write: ram_en = 0, ram_wr = 1, data still driven (hold). FINISH, read: ram_en = 1, ram_oe = 1, ram_data sampled into the winner's rdata at end of cycle.
REQ-024 FINISH -> IDLE unconditionally; the winner's ack pulses in that IDLE cycle; ram_en, ram_oe, ram_wr = 0 and ram_data = Z in IDLE.
REQ-025 Latency: req sampled in IDLE at cycle 0 -> gnt cycle 1 -> ack cycle 4; back-to-back throughput one access per 4 cycles (new SETUP may follow the ack cycle's IDLE).
REQ-026 CLEAR: ram_rst = 1 for exactly one cycle with ram_en = 0, ram_data = Z; next cycle IDLE with clr_ack = 1; clr_req is level, re-sampled only in IDLE.
REQ-027 A request arriving in a non-IDLE state SHALL wait; requests are never dropped or granted twice for one req assertion once gnt is seen.
REQ-028 ram_wr SHALL never change while ram_en = 1; ram_en and ram_rst SHALL never be high together.
REQ-029 Round-robin pointer SHALL update only on grant; clear does not change it.

Reset
REQ-030 On rst_n low, immediately: state IDLE; gnt, ack, clr_ack, busy, ram_en, ram_wr, ram_oe, ram_rst = 0; ram_addr = 0; ram_data = Z; rdata_a/b = 0; priority to A.
REQ-031 Reset mid-access SHALL abort without ack; operation is not retried.

Verification
REQ-032 Write A addr 5 data 16'hBEEF, then read A addr 5 -> gnt_a cycle 1, ack_a cycle 4 each; read ack with rdata_a = 16'hBEEF.
REQ-033 req_a and req_b both high every cycle from reset -> grants A,B,A,B; each ack 3 cycles after its gnt.
REQ-034 clr_req and req_a high together in IDLE -> ram_rst one cycle, clr_ack, then gnt_a; subsequent read of any address returns 16'h0000.
REQ-035 Write B addr 7 16'h1234 -> ram_en high only in STROBE; ram_data = 16'h1234 through SETUP..FINISH, Z in IDLE; ram_wr stable while ram_en high.
REQ-036 rst_n low during STROBE of a read -> all outputs at reset values asynchronously; no ack; after release, req_b alone granted on next cycle pair.

Source files
------------

// File: rtl/sp_ram_arbiter.sv
// -----------------------------------------------------------------------------
// sp_ram_arbiter
// Lets two requesters (A and B) share one single-port RAM. When both ask at
// once, round-robin arbitration picks the winner. A clear request zeroes the
// whole RAM. Every access runs through a four-state handshake on the RAM side:
// SETUP -> STROBE -> FINISH -> back to IDLE.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_x, we_x, addr_x,       per-port command, held until gnt_x
//   wdata_x
//   gnt_x                      1-cycle pulse: command captured
//   ack_x                      1-cycle pulse: access complete
//   rdata_x                    read data, updated in the read ack cycle
//   clr_req / clr_ack          clear-whole-RAM request / completion pulse
//   busy                       high whenever the FSM is not in IDLE
//   ram_en, ram_wr, ram_oe,    RAM strobe, write select, output enable and
//   ram_rst, ram_addr          clear, plus the RAM address
//   ram_data                   bidirectional RAM data bus
//   dbg_state                  current FSM state, for observation only
//
// Handshake: a requester holds req high with a stable command until it sees
// gnt. After that it may change its inputs. Completion is reported later by
// ack. If req is still high after gnt, it counts as a fresh request.
// -----------------------------------------------------------------------------
module sp_ram_arbiter #(
   parameter int RAM_WIDTH = 16,
   parameter int ADDR_SIZE = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_a,
   input  logic                 req_b,
   input  logic                 we_a,
   input  logic                 we_b,
   input  logic [ADDR_SIZE-1:0] addr_a,
   input  logic [ADDR_SIZE-1:0] addr_b,
   input  logic [RAM_WIDTH-1:0] wdata_a,
   input  logic [RAM_WIDTH-1:0] wdata_b,
   output logic                 gnt_a,
   output logic                 gnt_b,
   output logic                 ack_a,
   output logic                 ack_b,
   output logic [RAM_WIDTH-1:0] rdata_a,
   output logic [RAM_WIDTH-1:0] rdata_b,
   input  logic                 clr_req,
   output logic                 clr_ack,
   output logic                 busy,
   output logic                 ram_en,
   output logic                 ram_wr,
   output logic                 ram_oe,
   output logic                 ram_rst,
   output logic [ADDR_SIZE-1:0] ram_addr,
   inout  wire  [RAM_WIDTH-1:0] ram_data,
   output logic [2:0]           dbg_state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      FINISH = 3'd3,
      CLEAR  = 3'd4
   } state_t;

   state_t                 r_state;
   state_t                 w_next;

   // Captured command of the current winner
   logic                   r_sel_b;
   logic                   r_we;
   logic [RAM_WIDTH-1:0]   r_wdata;
   // 1 = B wins the next tie, 0 = A wins the next tie
   logic                   r_prio_b;

   // Registered outputs
   logic                   r_gnt_a, r_gnt_b, r_ack_a, r_ack_b, r_clr_ack;
   logic                   r_busy, r_ram_en, r_ram_wr, r_ram_oe, r_ram_rst;
   logic                   r_drive;
   logic [ADDR_SIZE-1:0]   r_ram_addr;
   logic [RAM_WIDTH-1:0]   r_rdata_a, r_rdata_b;

   // Next-cycle values of the command and control signals
   logic                   w_capture;
   logic                   w_win_b;
   logic                   w_cmd_we;
   logic                   w_access;

   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      w_win_b   = 1'b0;
      case (r_state)
         IDLE: begin
            if (clr_req) begin
               w_next = CLEAR;
            end else if (req_a || req_b) begin
               w_next    = SETUP;
               w_capture = 1'b1;
               // B wins if it asks alone, or if both ask and B holds priority
               w_win_b   = req_b && (!req_a || r_prio_b);
            end
         end
         SETUP:   w_next = STROBE;
         STROBE:  w_next = FINISH;
         FINISH:  w_next = IDLE;
         CLEAR:   w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // On a capture, the command comes straight from the winner's inputs.
   // Otherwise the command already latched in r_we stays in force.
   always_comb begin
      w_cmd_we = r_we;
      if (w_capture) begin
         w_cmd_we = w_win_b ? we_b : we_a;
      end
      w_access = (w_next == SETUP) || (w_next == STROBE) || (w_next == FINISH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_sel_b    <= 1'b0;
         r_we       <= 1'b0;
         r_wdata    <= '0;
         r_prio_b   <= 1'b0;
         r_gnt_a    <= 1'b0;
         r_gnt_b    <= 1'b0;
         r_ack_a    <= 1'b0;
         r_ack_b    <= 1'b0;
         r_clr_ack  <= 1'b0;
         r_busy     <= 1'b0;
         r_ram_en   <= 1'b0;
         r_ram_wr   <= 1'b0;
         r_ram_oe   <= 1'b0;
         r_ram_rst  <= 1'b0;
         r_drive    <= 1'b0;
         r_ram_addr <= '0;
         r_rdata_a  <= '0;
         r_rdata_b  <= '0;
      end else begin
         r_state <= w_next;

         if (w_capture) begin
            r_sel_b    <= w_win_b;
            r_we       <= w_cmd_we;
            r_wdata    <= w_win_b ? wdata_b : wdata_a;
            r_ram_addr <= w_win_b ? addr_b : addr_a;
            // Priority moves only on a grant; the loser gets the next tie
            r_prio_b   <= !w_win_b;
         end

         r_gnt_a   <= w_capture && !w_win_b;
         r_gnt_b   <= w_capture &&  w_win_b;
         r_ack_a   <= (r_state == FINISH) && !r_sel_b;
         r_ack_b   <= (r_state == FINISH) &&  r_sel_b;
         r_clr_ack <= (r_state == CLEAR);
         r_busy    <= (w_next != IDLE);

         // A write strobes only in STROBE. A read keeps en high through FINISH
         // so the RAM keeps driving the bus while the data is sampled.
         r_ram_en  <= (w_next == STROBE) || ((w_next == FINISH) && !w_cmd_we);
         r_ram_oe  <= (w_next == FINISH) && !w_cmd_we;
         r_ram_wr  <= w_access && w_cmd_we;
         r_drive   <= w_access && w_cmd_we;
         r_ram_rst <= (w_next == CLEAR);

         // Sample the read data at the end of FINISH, so it is valid in the ack cycle
         if ((r_state == FINISH) && !r_we) begin
            if (r_sel_b) begin
               r_rdata_b <= ram_data;
            end else begin
               r_rdata_a <= ram_data;
            end
         end
      end
   end

   assign ram_data  = r_drive ? r_wdata : 'z;

   assign gnt_a     = r_gnt_a;
   assign gnt_b     = r_gnt_b;
   assign ack_a     = r_ack_a;
   assign ack_b     = r_ack_b;
   assign clr_ack   = r_clr_ack;
   assign busy      = r_busy;
   assign ram_en    = r_ram_en;
   assign ram_wr    = r_ram_wr;
   assign ram_oe    = r_ram_oe;
   assign ram_rst   = r_ram_rst;
   assign ram_addr  = r_ram_addr;
   assign rdata_a   = r_rdata_a;
   assign rdata_b   = r_rdata_b;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sp_ram_arbiter
// Directed bench for sp_ram_arbiter. The drivers push the expected
// gnt/ack/clr_ack events, each tagged with the cycle it should occur in,
// onto exp_q. A monitor pops one entry whenever the DUT pulses any of
// those outputs. A small RAM model sits on the RAM-side bus.
// -----------------------------------------------------------------------------
module tb_sp_ram_arbiter;
  localparam int W  = 16;
  localparam int AW = 3;

  localparam logic [2:0] K_GA = 3'd0, K_GB = 3'd1, K_AA = 3'd2, K_AB = 3'd3, K_CA = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          req_a = 0, req_b = 0, we_a = 0, we_b = 0, clr_req = 0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [W-1:0]  wdata_a = '0, wdata_b = '0;
  logic          gnt_a, gnt_b, ack_a, ack_b, clr_ack, busy;
  logic          ram_en, ram_wr, ram_oe, ram_rst;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  rdata_a, rdata_b;
  logic [2:0]    dbg_state;
  wire  [W-1:0]  ram_data;

  sp_ram_arbiter #(.RAM_WIDTH(W), .ADDR_SIZE(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .ack_a(ack_a), .ack_b(ack_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .clr_req(clr_req), .clr_ack(clr_ack), .busy(busy),
    .ram_en(ram_en), .ram_wr(ram_wr), .ram_oe(ram_oe), .ram_rst(ram_rst),
    .ram_addr(ram_addr), .ram_data(ram_data), .dbg_state(dbg_state)
  );

  // ---------------- RAM model ----------------
  logic [W-1:0] mem [0:7];
  logic [W-1:0] mem_rd;
  initial for (int i = 0; i < 8; i++) mem[i] = '0;
  assign mem_rd   = mem[ram_addr];
  assign ram_data = (ram_oe && !ram_wr) ? mem_rd : 'z;
  always @(posedge clk) begin
    if (ram_rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (ram_en && ram_wr) begin
      mem[ram_addr] <= ram_data;
    end
  end

  // ---------------- scoreboard ----------------
  // entry = {check_data, kind[2:0], cycle[15:0], data[15:0]}
  logic [35:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic push(input logic [2:0] kind, input int c, input bit chk, input logic [W-1:0] d);
    exp_q.push_back({chk, kind, c[15:0], d});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic prev_en, prev_wr;
  initial begin prev_en = 0; prev_wr = 0; end

  always @(negedge clk) begin
    logic [2:0]   k;
    logic [W-1:0] d;
    logic [35:0]  e, got;
    if (gnt_a || gnt_b || ack_a || ack_b || clr_ack) begin
      k = gnt_a ? K_GA : gnt_b ? K_GB : ack_a ? K_AA : ack_b ? K_AB : K_CA;
      d = ack_a ? rdata_a : rdata_b;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: kind=%0d at cycle %0d, none expected", k, cyc);
      end else begin
        e   = exp_q.pop_front();
        got = {e[35], k, cyc[15:0], e[35] ? d : 16'h0000};
        if (got !== e) begin
          errors++;
          $display("FAIL scoreboard: got kind=%0d cyc=%0d data=%h, expected kind=%0d cyc=%0d data=%h",
                   got[34:32], got[31:16], got[15:0], e[34:32], e[31:16], e[15:0]);
        end
      end
    end
    // RAM-side protocol rules, checked every cycle
    check("en_rst_exclusive", {31'd0, ram_en && ram_rst}, 32'd0);
    check("wr_stable_under_en", {31'd0, prev_en && ram_en && (prev_wr != ram_wr)}, 32'd0);
    prev_en = ram_en;
    prev_wr = ram_wr;
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_values();
    check("rst_gnt_a", {31'd0, gnt_a}, 0);
    check("rst_gnt_b", {31'd0, gnt_b}, 0);
    check("rst_ack_a", {31'd0, ack_a}, 0);
    check("rst_ack_b", {31'd0, ack_b}, 0);
    check("rst_clr_ack", {31'd0, clr_ack}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ram_en", {31'd0, ram_en}, 0);
    check("rst_ram_wr", {31'd0, ram_wr}, 0);
    check("rst_ram_oe", {31'd0, ram_oe}, 0);
    check("rst_ram_rst", {31'd0, ram_rst}, 0);
    check("rst_ram_addr", {29'd0, ram_addr}, 0);
    check("rst_rdata_a", {16'd0, rdata_a}, 0);
    check("rst_rdata_b", {16'd0, rdata_b}, 0);
    check("rst_state", {29'd0, dbg_state}, 0);
  endtask

  // Issues one access from an idle DUT, then checks the RAM-side bus in each phase.
  task automatic do_access(input bit pb, input bit we, input logic [AW-1:0] addr,
                           input logic [W-1:0] wd, input bit chk, input logic [W-1:0] erd);
    int c0;
    bit seen;
    c0 = cyc;
    push(pb ? K_GB : K_GA, c0 + 1, 1'b0, '0);
    push(pb ? K_AB : K_AA, c0 + 4, chk, erd);
    if (pb) begin req_b = 1; we_b = we; addr_b = addr; wdata_b = wd; end
    else    begin req_a = 1; we_a = we; addr_a = addr; wdata_a = wd; end
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = pb ? gnt_b : gnt_a;
    end
    if (pb) req_b = 0; else req_a = 0;
    if (!seen) begin
      check("gnt_timeout", 32'd0, 32'd1);
    end else begin
      // SETUP
      check("setup_en", {31'd0, ram_en}, 0);
      check("setup_oe", {31'd0, ram_oe}, 0);
      check("setup_wr", {31'd0, ram_wr}, {31'd0, we});
      check("setup_addr", {29'd0, ram_addr}, {29'd0, addr});
      if (we) check("setup_data", {16'd0, ram_data}, {16'd0, wd});
      @(negedge clk); // STROBE
      check("strobe_en", {31'd0, ram_en}, 1);
      check("strobe_wr", {31'd0, ram_wr}, {31'd0, we});
      if (we) check("strobe_data", {16'd0, ram_data}, {16'd0, wd});
      @(negedge clk); // FINISH
      check("finish_en", {31'd0, ram_en}, {31'd0, !we});
      check("finish_oe", {31'd0, ram_oe}, {31'd0, !we});
      check("finish_wr", {31'd0, ram_wr}, {31'd0, we});
      if (we) check("finish_data", {16'd0, ram_data}, {16'd0, wd});
      @(negedge clk); // IDLE, ack cycle
      check("idle_en", {31'd0, ram_en}, 0);
      check("idle_wr", {31'd0, ram_wr}, 0);
      check("idle_oe", {31'd0, ram_oe}, 0);
      check("idle_busy", {31'd0, busy}, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Both requesters hold req high: grants alternate A, B, A, B
    c0 = cyc;
    push(K_GA, c0 + 1, 0, '0);  push(K_AA, c0 + 4, 0, '0);
    push(K_GB, c0 + 5, 0, '0);  push(K_AB, c0 + 8, 0, '0);
    push(K_GA, c0 + 9, 0, '0);  push(K_AA, c0 + 12, 0, '0);
    push(K_GB, c0 + 13, 0, '0); push(K_AB, c0 + 16, 0, '0);
    req_a = 1; we_a = 1; addr_a = 3'd1; wdata_a = 16'h1111;
    req_b = 1; we_b = 1; addr_b = 3'd2; wdata_b = 16'h2222;
    repeat (13) @(negedge clk);
    req_a = 0; req_b = 0;
    repeat (3) @(negedge clk);

    // Write then read back on A; read B's earlier write
    do_access(0, 1, 3'd5, 16'hBEEF, 0, '0);
    do_access(0, 0, 3'd5, '0, 1, 16'hBEEF);
    do_access(1, 0, 3'd2, '0, 1, 16'h2222);
    // Write on B, with the bus checked in every phase
    do_access(1, 1, 3'd7, 16'h1234, 0, '0);
    do_access(1, 0, 3'd7, '0, 1, 16'h1234);

    // Clear and req_a together: clear first, then A's read sees zero
    c0 = cyc;
    push(K_CA, c0 + 2, 0, '0);
    push(K_GA, c0 + 3, 0, '0);
    push(K_AA, c0 + 6, 1, 16'h0000);
    clr_req = 1; req_a = 1; we_a = 0; addr_a = 3'd5;
    @(negedge clk);
    check("clear_ram_rst", {31'd0, ram_rst}, 1);
    check("clear_ram_en", {31'd0, ram_en}, 0);
    check("clear_state", {29'd0, dbg_state}, 4);
    @(negedge clk);
    check("clear_rst_done", {31'd0, ram_rst}, 0);
    clr_req = 0;
    @(negedge clk);
    req_a = 0;
    repeat (3) @(negedge clk);
    do_access(1, 0, 3'd7, '0, 1, 16'h0000);
    do_access(0, 1, 3'd3, 16'hDEAD, 0, '0);
    do_access(0, 0, 3'd3, '0, 1, 16'hDEAD);

    // Reset during the STROBE phase of a read on A: no ack follows
    c0 = cyc;
    push(K_GA, c0 + 1, 0, '0);
    req_a = 1; we_a = 0; addr_a = 3'd3;
    @(negedge clk);
    req_a = 0;
    @(negedge clk);
    check("abort_in_strobe", {29'd0, dbg_state}, 2);
    rst_n = 0;
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    do_access(1, 0, 3'd7, '0, 1, 16'h0000);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
